// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier.
// One conditional add plus one right shift per clock; start/busy request
// handshake on the input side and valid/ack handshake on the result side.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic [2*WIDTH-1:0] out,
  output logic               valid,
  input  logic               ack
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [2*WIDTH-1:0]   out_q, out_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       stepHi;
  logic [2*WIDTH-1:0]   pStep;
  logic                 lastStep;

  // Upper half of P plus the multiplicand, with carry-out, then the shifted partial product
  always_comb begin
    sum      = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
    stepHi   = p_q[0] ? sum : {1'b0, p_q[2*WIDTH-1:WIDTH]};
    pStep    = {stepHi, p_q[WIDTH-1:1]};
    lastStep = (cnt_q == CW'(1));
  end

  // Next-state logic: accept in IDLE, count steps in RUN, wait for ack in DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (lastStep) state_d = DONE;
      DONE:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; out only captures the finished product on the last step
  always_comb begin
    m_d   = m_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    out_d = out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d   = in1;
          p_d   = {{WIDTH{1'b0}}, in2};
          cnt_d = CW'(WIDTH);
        end
      end
      RUN: begin
        p_d   = pStep;
        cnt_d = cnt_q - CW'(1);
        if (lastStep) out_d = pStep;
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      m_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign valid = (state_q == DONE);
  assign out   = out_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: directed WIDTH=4 vectors with hand-computed
// products, an exhaustive WIDTH=4 sweep and random WIDTH=8 pairs. Expected
// results are queued at accept time and popped by monitors when valid rises.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, start, ack;
  logic [3:0] in1, in2;
  logic       busy, valid;
  logic [7:0] out;

  logic        rstnW8, startW8, ackW8;
  logic [7:0]  in1W8, in2W8;
  logic        busyW8, validW8;
  logic [15:0] outW8;

  shift_add_multiplier #(.WIDTH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .out(out), .valid(valid), .ack(ack)
  );

  shift_add_multiplier #(.WIDTH(8)) dutW8 (
    .clk(clk), .rstn(rstnW8), .start(startW8), .in1(in1W8), .in2(in2W8),
    .busy(busyW8), .out(outW8), .valid(validW8), .ack(ackW8)
  );

  typedef struct {
    logic [15:0] prod;
    int          acceptCycle;
  } expected_t;

  expected_t q4[$];
  expected_t q8[$];

  int         checks = 0;
  int         failures = 0;
  int         cycleCnt = 0;
  logic [7:0] lastOut = 8'h00;

  logic       validPrev = 1'b0;
  logic [7:0] outPrev = 8'h00;
  logic       validPrevW8 = 1'b0;

  // Free-running cycle counter used to measure accept-to-valid latency
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cycleCnt);
    end
  endtask

  // WIDTH=4 monitor: pop on valid rise, then require out to hold while valid stays high
  always @(negedge clk) begin
    expected_t e;
    if (valid === 1'b1 && validPrev !== 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid4 actual=1 expected=0 at cycle %0d", cycleCnt);
      end else begin
        e = q4.pop_front();
        checkOutput("product4", {8'h00, out}, e.prod);
        checkOutput("latency4", 16'(cycleCnt - e.acceptCycle), 16'd4);
      end
    end else if (valid === 1'b1 && validPrev === 1'b1) begin
      checkOutput("out_stable4", {8'h00, out}, {8'h00, outPrev});
    end
    if (valid === 1'b1) checkOutput("busy_in_done4", {15'h0, busy}, 16'd1);
    validPrev = valid;
    outPrev   = out;
  end

  // WIDTH=8 monitor: pop on valid rise and check product and latency
  always @(negedge clk) begin
    expected_t e;
    if (validW8 === 1'b1 && validPrevW8 !== 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid8 actual=1 expected=0 at cycle %0d", cycleCnt);
      end else begin
        e = q8.pop_front();
        checkOutput("product8", outW8, e.prod);
        checkOutput("latency8", 16'(cycleCnt - e.acceptCycle), 16'd8);
      end
    end
    validPrevW8 = validW8;
  end

  // Present one request for a single cycle while the WIDTH=4 design is idle
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input bit expectIt, input logic [7:0] expProd);
    @(negedge clk);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (expectIt) q4.push_back('{prod: {8'h00, expProd}, acceptCycle: cycleCnt});
    checkOutput("busy_after_accept", {15'h0, busy}, 16'd1);
  endtask

  // Bounded wait for valid; busy must stay high and out must keep the old product
  task automatic waitValid(input logic [7:0] holdOut);
    for (int i = 0; i < 12; i++) begin
      if (valid === 1'b1) break;
      checkOutput("busy_run", {15'h0, busy}, 16'd1);
      checkOutput("out_hold", {8'h00, out}, {8'h00, holdOut});
      @(negedge clk);
    end
    if (valid !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL valid_timeout actual=%b expected=1 at cycle %0d", valid, cycleCnt);
    end
  endtask

  // Hold ack low for a while, then acknowledge and confirm the return to IDLE
  task automatic finishOp(input int holdCycles);
    repeat (holdCycles) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkOutput("idle_busy", {15'h0, busy}, 16'd0);
    checkOutput("idle_valid", {15'h0, valid}, 16'd0);
  endtask

  task automatic runOp(input logic [3:0] a, input logic [3:0] b, input logic [7:0] expProd, input int holdCycles);
    applyStimulus(a, b, 1'b1, expProd);
    waitValid(lastOut);
    finishOp(holdCycles);
    checkOutput("out_after_ack", {8'h00, out}, {8'h00, expProd});
    lastOut = expProd;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycleCnt);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; ack = 1'b0; in1 = '0; in2 = '0;
    rstnW8 = 1'b0; startW8 = 1'b0; ackW8 = 1'b0; in1W8 = '0; in2W8 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {15'h0, busy}, 16'd0);
    checkOutput("reset_valid", {15'h0, valid}, 16'd0);
    checkOutput("reset_out", {8'h00, out}, 16'h0000);
    checkOutput("reset_out8", outW8, 16'h0000);
    rstn   = 1'b1;
    rstnW8 = 1'b1;

    $display("[TB] directed products");
    runOp(4'd15, 4'd15, 8'hE1, 0);
    runOp(4'd7, 4'd9, 8'h3F, 10);
    runOp(4'd0, 4'd13, 8'h00, 0);
    runOp(4'd11, 4'd0, 8'h00, 0);

    $display("[TB] inputs and start ignored during RUN, start ignored in DONE");
    applyStimulus(4'd5, 4'd6, 1'b1, 8'h1E);
    for (int i = 0; i < 3; i++) begin
      in1   = 4'($urandom_range(0, 15));
      in2   = 4'($urandom_range(0, 15));
      start = (i == 1);
      @(negedge clk);
    end
    start = 1'b0;
    waitValid(lastOut);
    in1   = 4'd2;
    in2   = 4'd3;
    start = 1'b1;
    ack   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b0;
    checkOutput("start_ack_busy", {15'h0, busy}, 16'd0);
    checkOutput("start_ack_valid", {15'h0, valid}, 16'd0);
    checkOutput("start_ack_out", {8'h00, out}, 16'h001E);
    repeat (6) begin
      @(negedge clk);
      checkOutput("no_restart", {15'h0, busy}, 16'd0);
    end
    lastOut = 8'h1E;

    $display("[TB] reset aborts RUN");
    applyStimulus(4'd12, 4'd12, 1'b0, 8'h00);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checkOutput("abort_busy", {15'h0, busy}, 16'd0);
    checkOutput("abort_valid", {15'h0, valid}, 16'd0);
    checkOutput("abort_out", {8'h00, out}, 16'h0000);
    lastOut = 8'h00;
    runOp(4'd3, 4'd4, 8'h0C, 0);

    $display("[TB] exhaustive WIDTH=4 sweep");
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        runOp(4'(a), 4'(b), 8'(a * b), 0);
      end
    end

    $display("[TB] random WIDTH=8 pairs");
    for (int n = 0; n < 1000; n++) begin
      int a, b;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      @(negedge clk);
      in1W8   = 8'(a);
      in2W8   = 8'(b);
      startW8 = 1'b1;
      @(negedge clk);
      startW8 = 1'b0;
      q8.push_back('{prod: 16'(a * b), acceptCycle: cycleCnt});
      for (int i = 0; i < 20; i++) begin
        if (validW8 === 1'b1) break;
        @(negedge clk);
      end
      if (validW8 !== 1'b1) begin
        checks++;
        failures++;
        $display("[TB] FAIL valid8_timeout actual=%b expected=1 at cycle %0d", validW8, cycleCnt);
      end
      ackW8 = 1'b1;
      @(negedge clk);
      ackW8 = 1'b0;
    end

    repeat (3) @(negedge clk);
    checkOutput("queue4_drained", 16'(q4.size()), 16'd0);
    checkOutput("queue8_drained", 16'(q8.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
